cross_bar_slave_resp: RTL and testbench
=======================================

// Module: cross_bar_slave_resp
// PURPOSE
//   Memory-backed responder for one cross_bar_top slave port. It answers
//   slave_req/slave_cmd with slave_ack/slave_rdata after a configurable wait.
//   The register file is DEPTH words deep. Used as the bench and FPGA endpoint
//   behind each crossbar slave port; one instance per slave index.
// PARAMETERS
//   DEPTH     16  words in local register file; power of 2, >=2; IDX_W=$clog2(DEPTH)
//   WAIT_CYC  1   fixed wait states between request capture and ack; 0..15
//   CNT_W     16  width of transaction counter
// PORTS
//   clk          in   1         system clock, all logic on posedge
//   areset       in   1         asynchronous, active-high reset
//   slave_req    in   1         request from crossbar, held until ack
//   slave_addr   in   addr_t    byte-agnostic word address; only [IDX_W-1:0] used
//   slave_cmd    in   1         CMD_WRITE=1 / CMD_READ=0
//   slave_wdata  in   data_t    write data, valid with req
//   slave_ack    out  1         one-cycle completion pulse
//   slave_rdata  out  data_t    read data, valid in ack cycle of a read
//   txn_cnt      out  CNT_W     completed transactions, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   Reset (async, high): state=IDLE; slave_ack=0; slave_rdata=0; txn_cnt=0;
//     all mem words=0; wait counter=0; capture regs=0. A reset during WAIT/ACK
//     abandons the transaction; no write occurs and no ack is issued.
//   FSM: IDLE -> WAIT -> ACK -> IDLE.
//   IDLE: on slave_req=1, capture addr[IDX_W-1:0], cmd and wdata; load wcnt=wait.
//     If wait==0 go to ACK, else go to WAIT.
//   WAIT: wcnt decrements each cycle; when wcnt==1 go to ACK.
//   ACK: slave_ack=1 for exactly one cycle. Read: slave_rdata=mem[idx], driven
//     registered in the same cycle. Write: mem[idx]<=wdata at the end of the
//     ACK cycle, and slave_rdata keeps its previous value. txn_cnt+1 at the end
//     of ACK. Next state is always IDLE.
//   Latency: req sampled at edge N -> ack high during cycle N+wait+1.
//     Minimum spacing is 2 cycles per transaction (IDLE must be revisited).
//   req deasserted during WAIT: the transaction still completes from the
//     captured values.
//   req still high in the cycle after ack: treated as a new request.
//   Read-after-write to the same idx in the next transaction returns new data.
//   slave_addr bits above IDX_W-1 are ignored; the crossbar decodes them.
// CONFIGURATION
//   CROSS_BAR_SLAVE_RAND_WAIT_EN defined: wait=WAIT_CYC+lfsr[1:0] (WAIT_CYC..WAIT_CYC+3).
//     lfsr is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
//     It advances once per accepted request, in the IDLE capture cycle.
//   Not defined: wait=WAIT_CYC always; no LFSR logic is synthesised.
// STRUCTURE
//   cross_bar_pkg gains CMD_READ=1'b0 and CMD_WRITE=1'b1, and a resp_state_t enum
//     {RS_IDLE,RS_WAIT,RS_ACK}. addr_t and data_t are reused from the package.
//   One sub-module: cross_bar_lfsr8 (clk, areset, adv, q[7:0]). It is
//     instantiated only under CROSS_BAR_SLAVE_RAND_WAIT_EN.
// TESTING
//   1 Reset: assert areset mid-sim -> ack=0, rdata=0, txn_cnt=0 immediately,
//     without waiting for a clock edge.
//   2 WAIT_CYC=2: write idx3=32'hDEAD_BEEF at edge 10 -> ack in cycle 13 only.
//     Then read idx3 -> rdata=32'hDEAD_BEEF with ack; txn_cnt=2.
//   3 Read an unwritten idx5 after reset -> rdata=0. Address 0x...13 with DEPTH=16
//     -> accesses idx3 (upper bits ignored).
//   4 Drop req one cycle after capture (WAIT_CYC=3) -> ack still arrives at N+4
//     and the write lands.
//   5 Assert areset during WAIT of a write to idx7 -> no ack; idx7 reads 0 afterwards.
//   6 WAIT_CYC=0, req held high for 10 cycles -> 5 acks, one every 2nd cycle.
//     txn_cnt=5. With CROSS_BAR_SLAVE_RAND_WAIT_EN, every ack latency is in
//     [1,4] and the sequence repeats after reset.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared crossbar types: address/data words, command encoding, slave responder state.
package cross_bar_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  // Wide enough for WAIT_CYC=15 plus the random extra wait of up to 3
  localparam int WCNT_W = 5;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_ACK} resp_state_t;
endpackage

// File: rtl/cross_bar_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5, steps once per adv.
module cross_bar_lfsr8 (
  input  logic       clk,
  input  logic       areset,
  input  logic       adv,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge areset) begin
    if (areset)   q <= 8'hA5;
    else if (adv) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end
endmodule

// File: rtl/cross_bar_slave_resp.sv
// Register-file responder for one crossbar slave port: IDLE -> WAIT -> ACK.
// Define CROSS_BAR_SLAVE_RAND_WAIT_EN to add 0..3 LFSR-driven extra wait states.
module cross_bar_slave_resp
  import cross_bar_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             slave_req,
  input  addr_t            slave_addr,
  input  logic             slave_cmd,
  input  data_t            slave_wdata,
  output logic             slave_ack,
  output data_t            slave_rdata,
  output logic [CNT_W-1:0] txn_cnt
);
  localparam int IDX_W = $clog2(DEPTH);

  resp_state_t       state, nxt;
  logic [WCNT_W-1:0] wcnt, wait_ld;
  logic [IDX_W-1:0]  cap_idx, acc_idx;
  logic              cap_cmd, acc_cmd, accept;
  data_t             cap_wdata;
  data_t             mem [DEPTH];

  // Upper address bits are decoded by the crossbar, not here
  logic unused_addr_hi;
  assign unused_addr_hi = ^slave_addr[ADDR_W-1:IDX_W];

  assign accept = (state == RS_IDLE) && slave_req;

`ifdef CROSS_BAR_SLAVE_RAND_WAIT_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr_hi;
  cross_bar_lfsr8 u_lfsr (.clk(clk), .areset(areset), .adv(accept), .q(lfsr_q));
  assign unused_lfsr_hi = ^lfsr_q[7:2];
  assign wait_ld = WCNT_W'(WAIT_CYC) + {{(WCNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign wait_ld = WCNT_W'(WAIT_CYC);
`endif

  // With zero wait the read happens on the capture edge, so bypass the capture regs
  assign acc_idx = accept ? slave_addr[IDX_W-1:0] : cap_idx;
  assign acc_cmd = accept ? slave_cmd : cap_cmd;

  always_comb begin
    nxt = state;
    case (state)
      RS_IDLE: if (slave_req) nxt = (wait_ld == '0) ? RS_ACK : RS_WAIT;
      RS_WAIT: if (wcnt == WCNT_W'(1)) nxt = RS_ACK;
      RS_ACK:  nxt = RS_IDLE;
      default: nxt = RS_IDLE;
    endcase
  end

  assign slave_ack = (state == RS_ACK);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= RS_IDLE;
      wcnt        <= '0;
      cap_idx     <= '0;
      cap_cmd     <= CMD_READ;
      cap_wdata   <= '0;
      slave_rdata <= '0;
      txn_cnt     <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cap_idx   <= slave_addr[IDX_W-1:0];
        cap_cmd   <= slave_cmd;
        cap_wdata <= slave_wdata;
        wcnt      <= wait_ld;
      end else if (state == RS_WAIT) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
      if (nxt == RS_ACK && acc_cmd == CMD_READ) slave_rdata <= mem[acc_idx];
      if (state == RS_ACK) txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

  // Writes commit as the ACK cycle ends, so an abandoned transaction never lands
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == RS_ACK && cap_cmd == CMD_WRITE) begin
      mem[cap_idx] <= cap_wdata;
    end
  end
endmodule

// File: tb/tb_cross_bar_slave_resp.sv
// Bench for cross_bar_slave_resp: three responders (wait 0/2/3) against a queue-free array model.
module tb_cross_bar_slave_resp;
  import cross_bar_pkg::*;

  logic        clk = 0;
  logic        areset = 1;
  logic        req   [3];
  addr_t       addr_v[3];
  logic        cmd_v [3];
  data_t       wd_v  [3];
  logic        ack_v [3];
  data_t       rd_v  [3];
  logic [15:0] cnt_v [3];

  int    vectors = 0, miscompares = 0;
  data_t mm [3][16];
  data_t lr [3];
  int    cm [3];
  int    wt [3] = '{0, 2, 3};

  always #5 clk = ~clk;

  cross_bar_slave_resp #(.DEPTH(16), .WAIT_CYC(0), .CNT_W(16)) u_w0 (
    .clk(clk), .areset(areset), .slave_req(req[0]), .slave_addr(addr_v[0]), .slave_cmd(cmd_v[0]),
    .slave_wdata(wd_v[0]), .slave_ack(ack_v[0]), .slave_rdata(rd_v[0]), .txn_cnt(cnt_v[0]));
  cross_bar_slave_resp #(.DEPTH(16), .WAIT_CYC(2), .CNT_W(16)) u_w2 (
    .clk(clk), .areset(areset), .slave_req(req[1]), .slave_addr(addr_v[1]), .slave_cmd(cmd_v[1]),
    .slave_wdata(wd_v[1]), .slave_ack(ack_v[1]), .slave_rdata(rd_v[1]), .txn_cnt(cnt_v[1]));
  cross_bar_slave_resp #(.DEPTH(16), .WAIT_CYC(3), .CNT_W(16)) u_w3 (
    .clk(clk), .areset(areset), .slave_req(req[2]), .slave_addr(addr_v[2]), .slave_cmd(cmd_v[2]),
    .slave_wdata(wd_v[2]), .slave_ack(ack_v[2]), .slave_rdata(rd_v[2]), .txn_cnt(cnt_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) mm[d][i] = '0;
      lr[d] = '0;
      cm[d] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_ack"}, 32'(ack_v[d]), 32'd0);
      chk({tag, "_rdata"}, rd_v[d], 32'd0);
      chk({tag, "_cnt"}, 32'(cnt_v[d]), 32'd0);
    end
  endtask

  // One transaction on responder d; drop releases req right after capture.
  task automatic txn(input int d, input logic c, input addr_t a, input data_t w, input bit drop);
    int lat;
    bit got;
    int idx;
    idx = int'(a % 16);
    @(negedge clk);
    req[d] = 1'b1; cmd_v[d] = c; addr_v[d] = a; wd_v[d] = w;
    @(posedge clk);
    lat = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (drop) req[d] = 1'b0;
      if (ack_v[d]) got = 1; else lat++;
    end
    req[d] = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", lat, wt[d]);
    if (c == CMD_READ) begin
      lr[d] = mm[d][idx];
      chk("rdata", rd_v[d], lr[d]);
    end else begin
      chk("rdata_hold", rd_v[d], lr[d]);
      mm[d][idx] = w;
    end
    cm[d]++;
    @(negedge clk);
    chk("ack_pulse", 32'(ack_v[d]), 32'd0);
    chk("txn_cnt", 32'(cnt_v[d]), 32'(cm[d] % 65536));
  endtask

  initial begin
    int acks;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; addr_v[d] = '0; cmd_v[d] = 0; wd_v[d] = '0;
    end
    model_reset();
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    areset = 0;

    // wait=2 write then read back, plus an untouched word
    txn(1, CMD_WRITE, 32'h0000_0003, 32'hDEAD_BEEF, 0);
    txn(1, CMD_READ,  32'h0000_0003, 32'h0, 0);
    chk("cnt_after_two", 32'(cnt_v[1]), 32'd2);
    txn(1, CMD_READ,  32'h0000_0005, 32'h0, 0);
    // upper address bits alias onto idx3
    txn(1, CMD_WRITE, 32'hABCD_0013, 32'h1234_5678, 0);
    txn(1, CMD_READ,  32'h0000_0003, 32'h0, 0);

    // mid-sim reset clears outputs without a clock edge
    @(negedge clk);
    areset = 1;
    #1;
    chk_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    areset = 0;

    // req dropped after capture: wait=3 still completes and writes
    txn(2, CMD_WRITE, 32'h0000_0004, 32'hCAFE_F00D, 1);
    txn(2, CMD_READ,  32'h0000_0004, 32'h0, 0);

    // reset in WAIT abandons the write to idx7
    txn(2, CMD_WRITE, 32'h0000_0007, 32'h1111_2222, 0);
    @(negedge clk);
    req[2] = 1; cmd_v[2] = CMD_WRITE; addr_v[2] = 32'h7; wd_v[2] = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    req[2] = 0;
    areset = 1;
    #1;
    chk("rst_wait_ack", 32'(ack_v[2]), 32'd0);
    model_reset();
    @(negedge clk);
    areset = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_v[2]) acks++;
    end
    chk("rst_wait_no_ack", acks, 0);
    txn(2, CMD_READ, 32'h0000_0007, 32'h0, 0);

    // wait=0, req held for 10 cycles -> ack every other cycle
    @(negedge clk);
    req[0] = 1; cmd_v[0] = CMD_WRITE; addr_v[0] = 32'h9; wd_v[0] = 32'h0BAD_CAFE;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_v[0]) begin
        acks++;
        chk("b2b_phase", 32'(i % 2), 32'd0);
      end
    end
    req[0] = 0;
    cm[0] += 5;
    mm[0][9] = 32'h0BAD_CAFE;
    chk("b2b_acks", acks, 5);
    chk("b2b_cnt", 32'(cnt_v[0]), 32'(cm[0]));
    txn(0, CMD_READ, 32'h0000_0009, 32'h0, 0);

    // random traffic across all three responders
    for (int n = 0; n < 60; n++) begin
      int    d;
      logic  c;
      addr_t a;
      data_t w;
      d = int'($urandom_range(2, 0));
      c = 1'($urandom_range(1, 0));
      a = $urandom;
      w = $urandom;
      txn(d, c, a, w, 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
